// File: rtl/tpu_seq_pkg.sv
// Shared types and default frame headers for the TPU frame sequencer.
package tpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRID  = 3'd1,
        MLEN  = 3'd2,
        MOVES = 3'd3,
        WAIT  = 3'd4
    } seq_state_e;

    localparam logic [7:0] DEF_GRID_HEADER = 8'b11010101;
    localparam logic [7:0] DEF_MOVE_HEADER = 8'b11101010;

endpackage

// File: rtl/tpu_frame_sequencer.sv
// TPU frame sequencer: sits between the SPI slave byte stream and the TPU.
// It forwards well-formed GRID/MOVE frames one cycle late, drops stray
// bytes with an error pulse, and holds off new frames until tpu_done.
// Optional build macro SEQ_TIMEOUT_EN adds a mid-frame idle watchdog.
module tpu_frame_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] GRID_HEADER = DATA_WIDTH'(DEF_GRID_HEADER),
    parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = DATA_WIDTH'(DEF_MOVE_HEADER),
    parameter int                    GRID_BYTES  = 16,
    parameter int                    MAX_MOVES   = 220,
    parameter int                    TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  rx_v,
    input  logic [DATA_WIDTH-1:0] rx_d,
    input  logic                  tpu_done,
    output logic                  tpu_iv,
    output logic [DATA_WIDTH-1:0] tpu_id,
    output logic                  seq_busy,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            err_cnt
);

    // Payload counter holds up to 2*N move bytes, N being one length byte.
    localparam int CNT_W = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(MAX_MOVES);

    if (GRID_BYTES < 1 || GRID_BYTES >= (1 << CNT_W)) begin : g_bad_grid
        $error("GRID_BYTES does not fit the payload counter");
    end
    if (MAX_MOVES < 1 || 2 * MAX_MOVES >= (1 << CNT_W)) begin : g_bad_moves
        $error("MAX_MOVES does not fit the payload counter");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    // Saturating increment for the error counter; it never wraps.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  iv_q, iv_d;
    logic [DATA_WIDTH-1:0] id_q, id_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);
    logic [WD_W-1:0]       wd_q, wd_d;
`endif

    // Next-state, forwarding and error decisions for one incoming byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iv_d    = 1'b0;
        id_d    = id_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_v) begin
                    if (rx_d == GRID_HEADER) begin
                        iv_d    = 1'b1;
                        id_d    = rx_d;
                        cnt_d   = CNT_W'(GRID_BYTES);
                        state_d = GRID;
                    end else if (rx_d == MOVE_HEADER) begin
                        iv_d    = 1'b1;
                        id_d    = rx_d;
                        state_d = MLEN;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            GRID, MOVES: begin
                if (rx_v) begin
                    iv_d  = 1'b1;
                    id_d  = rx_d;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        ok_d    = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            MLEN: begin
                if (rx_v) begin
                    if (rx_d == '0 || rx_d > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Each move is two bytes on the wire.
                        iv_d    = 1'b1;
                        id_d    = rx_d;
                        cnt_d   = {rx_d, 1'b0};
                        state_d = MOVES;
                    end
                end
            end
            WAIT: begin
                // A byte arriving with tpu_done is still dropped, never parsed.
                if (rx_v) begin
                    err_d = 1'b1;
                end
                if (tpu_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SEQ_TIMEOUT_EN
        // Watchdog only runs mid-frame; any byte or state exit clears it.
        // It can only fire when rx_v is low, so it never collides with frame_ok.
        wd_d = '0;
        if ((state_q == GRID || state_q == MLEN || state_q == MOVES) && !rx_v) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif

        err_cnt_d = err_d ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    // Sequencer state and registered outputs; reset discards any frame in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            iv_q      <= 1'b0;
            id_q      <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
`ifdef SEQ_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            iv_q      <= iv_d;
            id_q      <= id_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign tpu_iv    = iv_q;
    assign tpu_id    = id_q;
    assign seq_busy  = (state_q != IDLE);
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tpu_frame_sequencer.sv
// Directed bench for tpu_frame_sequencer with hand-computed expectations.
module tb_tpu_frame_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx_v = 1'b0;
    logic [7:0] rx_d = 8'h00;
    logic       tpu_done = 1'b0;
    logic       tpu_iv;
    logic [7:0] tpu_id;
    logic       seq_busy;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fwd_cnt;
    int ok_cnt;

    always #5 clk = ~clk;

    tpu_frame_sequencer #(
        .DATA_WIDTH (8),
        .GRID_BYTES (16),
        .MAX_MOVES  (220),
        .TIMEOUT    (8)
    ) u_dut (
        .clk       (clk),
        .nrst      (nrst),
        .rx_v      (rx_v),
        .rx_d      (rx_d),
        .tpu_done  (tpu_done),
        .tpu_iv    (tpu_iv),
        .tpu_id    (tpu_id),
        .seq_busy  (seq_busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle, then check the registered response.
    task automatic send(input logic [7:0] b, input logic e_iv, input logic e_ok,
                        input logic e_err, input string tag);
        rx_v = 1'b1;
        rx_d = b;
        tick();
        rx_v = 1'b0;
        if (tpu_iv) fwd_cnt++;
        if (frame_ok) ok_cnt++;
        chk({tag, ".iv"}, 32'(tpu_iv), 32'(e_iv));
        if (e_iv) chk({tag, ".id"}, 32'(tpu_id), 32'(b));
        chk({tag, ".ok"}, 32'(frame_ok), 32'(e_ok));
        chk({tag, ".err"}, 32'(frame_err), 32'(e_err));
    endtask

    task automatic done_pulse();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
    endtask

    task automatic grid_frame(input string tag);
        fwd_cnt = 0;
        ok_cnt  = 0;
        send(8'hD5, 1'b1, 1'b0, 1'b0, {tag, ".hdr"});
        for (int i = 0; i < 16; i++) begin
            send(8'(i * 7 + 3), 1'b1, (i == 15), 1'b0, {tag, ".pay"});
            chk({tag, ".busy"}, 32'(seq_busy), 32'd1);
        end
        chk({tag, ".fwd"}, 32'(fwd_cnt), 32'd17);
        chk({tag, ".okcnt"}, 32'(ok_cnt), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.iv", 32'(tpu_iv), 32'd0);
        chk("rst.id", 32'(tpu_id), 32'd0);
        chk("rst.busy", 32'(seq_busy), 32'd0);
        chk("rst.ok", 32'(frame_ok), 32'd0);
        chk("rst.err", 32'(frame_err), 32'd0);
        chk("rst.ecnt", 32'(err_cnt), 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        // 1: grid frame, then release by tpu_done
        grid_frame("t1");
        tick();
        chk("t1.idle_iv", 32'(tpu_iv), 32'd0);
        chk("t1.wait_busy", 32'(seq_busy), 32'd1);
        done_pulse();
        chk("t1.done_busy", 32'(seq_busy), 32'd0);

        // 2: garbage then a two-move frame
        send(8'h00, 1'b0, 1'b0, 1'b1, "t2.g0");
        send(8'hFF, 1'b0, 1'b0, 1'b1, "t2.gff");
        chk("t2.ecnt", 32'(err_cnt), 32'd2);
        fwd_cnt = 0;
        send(8'hEA, 1'b1, 1'b0, 1'b0, "t2.hdr");
        send(8'h02, 1'b1, 1'b0, 1'b0, "t2.len");
        for (int i = 0; i < 4; i++)
            send(8'(8'h40 + i), 1'b1, (i == 3), 1'b0, "t2.mv");
        chk("t2.fwd", 32'(fwd_cnt), 32'd6);
        done_pulse();
        chk("t2.busy", 32'(seq_busy), 32'd0);

        // 3: invalid lengths 0 and 221
        send(8'hEA, 1'b1, 1'b0, 1'b0, "t3.hdr0");
        send(8'h00, 1'b0, 1'b0, 1'b1, "t3.len0");
        chk("t3.busy0", 32'(seq_busy), 32'd0);
        send(8'hEA, 1'b1, 1'b0, 1'b0, "t3.hdr221");
        send(8'hDD, 1'b0, 1'b0, 1'b1, "t3.len221");
        chk("t3.busy221", 32'(seq_busy), 32'd0);
        chk("t3.ecnt", 32'(err_cnt), 32'd4);

        // 3b: largest legal length, 220 moves = 440 bytes
        fwd_cnt = 0;
        ok_cnt  = 0;
        send(8'hEA, 1'b1, 1'b0, 1'b0, "t3b.hdr");
        send(8'hDC, 1'b1, 1'b0, 1'b0, "t3b.len");
        for (int i = 0; i < 440; i++)
            send(8'(i), 1'b1, (i == 439), 1'b0, "t3b.mv");
        chk("t3b.fwd", 32'(fwd_cnt), 32'd442);
        chk("t3b.okcnt", 32'(ok_cnt), 32'd1);
        chk("t3b.ecnt", 32'(err_cnt), 32'd4);

        // 4: bytes in WAIT, and tpu_done colliding with a header byte
        send(8'h33, 1'b0, 1'b0, 1'b1, "t4.wait");
        chk("t4.busy", 32'(seq_busy), 32'd1);
        tpu_done = 1'b1;
        send(8'hD5, 1'b0, 1'b0, 1'b1, "t4.coll");
        tpu_done = 1'b0;
        chk("t4.coll_busy", 32'(seq_busy), 32'd0);
        chk("t4.ecnt", 32'(err_cnt), 32'd6);
        done_pulse();
        chk("t4.idle_done", 32'(seq_busy), 32'd0);
        chk("t4.idle_err", 32'(frame_err), 32'd0);

        // 5: reset mid-grid, then a clean frame
        send(8'hD5, 1'b1, 1'b0, 1'b0, "t5.hdr");
        for (int i = 0; i < 5; i++)
            send(8'(8'h10 + i), 1'b1, 1'b0, 1'b0, "t5.pay");
        #2;
        nrst = 1'b0;
        #1;
        chk("t5.rst_iv", 32'(tpu_iv), 32'd0);
        chk("t5.rst_id", 32'(tpu_id), 32'd0);
        chk("t5.rst_busy", 32'(seq_busy), 32'd0);
        chk("t5.rst_ecnt", 32'(err_cnt), 32'd0);
        tick();
        nrst = 1'b1;
        tick();
        grid_frame("t5b");
        done_pulse();
        chk("t5b.busy", 32'(seq_busy), 32'd0);
        chk("t5b.ecnt", 32'(err_cnt), 32'd0);

        // Error counter saturation
        for (int i = 0; i < 260; i++)
            send(8'h11, 1'b0, 1'b0, 1'b1, "sat.g");
        chk("sat.ecnt", 32'(err_cnt), 32'd255);

        // 6: truncated grid frame followed by silence
        send(8'hD5, 1'b1, 1'b0, 1'b0, "t6.hdr");
        for (int i = 0; i < 3; i++)
            send(8'(8'h20 + i), 1'b1, 1'b0, 1'b0, "t6.pay");
`ifdef SEQ_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t6.pre_err", 32'(frame_err), 32'd0);
            chk("t6.pre_busy", 32'(seq_busy), 32'd1);
        end
        tick();
        chk("t6.to_err", 32'(frame_err), 32'd1);
        chk("t6.to_busy", 32'(seq_busy), 32'd0);
        chk("t6.to_ecnt", 32'(err_cnt), 32'd255);
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t6.no_err", 32'(frame_err), 32'd0);
            chk("t6.no_busy", 32'(seq_busy), 32'd1);
        end
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
